envelope_channel_scheduler: RTL and testbench
=============================================

# envelope_channel_scheduler

Round-robin scheduler that shares one 8-tap moving-average envelope datapath among NUM_CH audio channels. It accepts one sample at a time from per-channel valid/ready inputs and stores it in that channel's private 8-entry history. It then sequences a single shared accumulator over the eight stored samples and presents the channel-tagged envelope value on a valid/ready output. It sits between the per-channel sample front end and the downstream envelope consumers, replacing per-channel averager instances.

## Interface
- SAMPLE_WIDTH, 24, unsigned sample/envelope width
- NUM_CH, 4, number of channels (2..8)
- sample_clock  in  1  sample-domain clock (96 kHz class; single clock)
- rst  in  1  synchronous, active-low reset
- in_valid  in  NUM_CH  per-channel sample valid
- in_ready  out  NUM_CH  per-channel accept; at most one bit high
- in_sample  in  NUM_CH*SAMPLE_WIDTH  channel i in bits [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]
- out_valid  out  1  envelope result valid
- out_ready  in  1  downstream accept
- out_channel  out  $clog2(NUM_CH)  channel index of out_sample
- out_sample  out  SAMPLE_WIDTH  envelope (mean of channel's last 8 samples)
- busy  out  1  high in any state other than IDLE

## Operation
- State: per channel, 8 history entries and a 3-bit write pointer wptr[ch]; rr_ptr (next-priority channel); grant register gch; 3-bit tap counter; accumulator of SAMPLE_WIDTH+3 bits.
- FSM states: IDLE, ACCUM, OUTPUT.
- IDLE:
  - Grant is the first channel with in_valid high, searching upward from rr_ptr with wrap.
  - in_ready is asserted only on the granted bit, combinationally.
  - On handshake: history[g][wptr[g]] <= sample; wptr[g]++ (wraps 7->0); gch <= g; accumulator and tap counter cleared; go to ACCUM.
  - No valid: stay in IDLE with rr_ptr unchanged.
- ACCUM: one tap per cycle. accumulator += history[gch][tap], for tap 0..7 (zero-extended). After tap 7, go to OUTPUT.
- OUTPUT:
  - out_valid = 1, out_channel = gch, out_sample = accumulator >> 3 (truncate; no rounding).
  - On out_valid & out_ready: rr_ptr <= gch+1 (mod NUM_CH); go to IDLE.
- in_ready is all-zero in ACCUM and OUTPUT. Upstream holds in_valid and data. Dropping in_valid without a handshake is allowed and simply forgoes the grant.
- Arithmetic is unsigned. Maximum sum is 8*(2^SAMPLE_WIDTH−1), which fits in SAMPLE_WIDTH+3 bits, so there is no overflow.
- Channel histories are independent. Other channels are untouched while one is served.

## Timing
- Reset (rst low at a clock edge):
  - State goes to IDLE; all history entries, wptr, rr_ptr, gch and accumulator are cleared.
  - Outputs: in_ready=0, out_valid=0, out_channel=0, out_sample=0, busy=0.
  - Reset mid-ACCUM/OUTPUT aborts the pending result; it is not emitted after release.
- Latency: input handshake at edge T. ACCUM occupies cycles T+1..T+8. out_valid rises after edge T+8 and is valid through cycle T+9 onward until accepted.
- Throughput: with out_ready held high, one sample per 10 cycles. Stalls extend OUTPUT indefinitely; out_* stay stable while out_valid=1 and out_ready=0.
- The earliest next in_ready is the cycle after the output handshake.
- out_sample and out_channel hold their last value when out_valid=0; the bench must not check them then.

## Test plan
- Reset then ch0 sends 8 samples of 0x000800, out_ready=1:
  - Results are 0x000100, 0x000200, …, 0x000800.
  - out_channel=0 each time.
  - out_valid is asserted exactly 9 cycles after each input handshake.
- Full scale: 8 samples of 0xFFFFFF on ch2 → final out_sample=0xFFFFFF. Then one sample 0x000000 → 0xDFFFFF (truncated).
- Fairness: all in_valid held high with distinct constant data per channel → grant order 0,1,2,3,0…. No channel is served twice while another valid channel waits.
- Backpressure: out_ready=0 for 20 cycles in OUTPUT → out_valid, out_channel and out_sample are stable; in_ready=0 throughout. Release → handshake, then IDLE.
- Isolation: ch1 sends 0x000080 ×8 and ch3 sends 0x000400 once. The ch3 result is 0x000080 and the ch1 history is unaffected; the next ch1 sample 0x000080 → 0x000080.
- Reset mid-ACCUM (rst low at tap 4) → no out_valid afterward. After release, the first ch0 sample 0x000008 yields 0x000001, showing the history was cleared.

Source files
------------

// File: rtl/envelope_channel_scheduler.sv
// Round-robin scheduler that time-shares one 8-tap moving-average accumulator
// across NUM_CH channels, each with its own 8-entry sample history.
module envelope_channel_scheduler #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int NUM_CH       = 4
) (
  input  logic                             sample_clock,
  input  logic                             rst,
  input  logic [NUM_CH-1:0]                in_valid,
  output logic [NUM_CH-1:0]                in_ready,
  input  logic [NUM_CH*SAMPLE_WIDTH-1:0]   in_sample,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(NUM_CH)-1:0]        out_channel,
  output logic [SAMPLE_WIDTH-1:0]          out_sample,
  output logic                             busy
);
  localparam int CW = $clog2(NUM_CH);
  localparam int AW = SAMPLE_WIDTH + 3;

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  state_t                  state_q, state_d;
  logic [SAMPLE_WIDTH-1:0] hist_q [NUM_CH][8];
  logic [SAMPLE_WIDTH-1:0] hist_d [NUM_CH][8];
  logic [2:0]              wptr_q [NUM_CH];
  logic [2:0]              wptr_d [NUM_CH];
  logic [CW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]           gch_q, gch_d;
  logic [2:0]              tap_q, tap_d;
  logic [AW-1:0]           acc_q, acc_d;

  logic [SAMPLE_WIDTH-1:0] samples [NUM_CH];
  logic                    grant_found;
  logic [CW-1:0]           grant;
  int                      idx;

  function automatic logic [CW-1:0] next_ch(input logic [CW-1:0] c);
    if (c == CW'(NUM_CH - 1)) return '0;
    return c + CW'(1);
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign samples[gi]  = in_sample[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      assign in_ready[gi] = rst && (state_q == IDLE) && grant_found && (grant == CW'(gi));
    end
  endgenerate

  // First requesting channel at or after rr_ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    idx         = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!grant_found && in_valid[CW'(idx)]) begin
        grant_found = 1'b1;
        grant       = CW'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    wptr_d   = wptr_q;
    rr_ptr_d = rr_ptr_q;
    gch_d    = gch_q;
    tap_d    = tap_q;
    acc_d    = acc_q;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          hist_d[grant][wptr_q[grant]] = samples[grant];
          wptr_d[grant] = wptr_q[grant] + 3'd1;
          gch_d   = grant;
          acc_d   = '0;
          tap_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + AW'(hist_q[gch_q][tap_q]);
        tap_d = tap_q + 3'd1;
        if (tap_q == 3'd7) state_d = OUTPUT;
      end
      OUTPUT: begin
        if (out_ready) begin
          rr_ptr_d = next_ch(gch_q);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sample_clock) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gch_q    <= '0;
      tap_q    <= '0;
      acc_q    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_q[c] <= '0;
        for (int e = 0; e < 8; e++) hist_q[c][e] <= '0;
      end
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      wptr_q   <= wptr_d;
      rr_ptr_q <= rr_ptr_d;
      gch_q    <= gch_d;
      tap_q    <= tap_d;
      acc_q    <= acc_d;
    end
  end

  assign out_valid   = (state_q == OUTPUT);
  assign out_channel = gch_q;
  assign out_sample  = SAMPLE_WIDTH'(acc_q >> 3);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_envelope_channel_scheduler.sv
// Scoreboard bench: a per-channel sliding-window model predicts each envelope,
// the grant order and the output timing; monitors compare against the DUT.
module tb_envelope_channel_scheduler;
  localparam int SW  = 24;
  localparam int NCH = 4;
  localparam int CW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    in_valid;
  logic [NCH-1:0]    in_ready;
  logic [NCH*SW-1:0] in_sample;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     out_channel;
  logic [SW-1:0]     out_sample;
  logic              busy;

  always #5 clk = ~clk;

  envelope_channel_scheduler #(.SAMPLE_WIDTH(SW), .NUM_CH(NCH)) dut (
    .sample_clock(clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sample   (in_sample),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_channel (out_channel),
    .out_sample  (out_sample),
    .busy        (busy)
  );

  typedef struct {
    int          ch;
    logic [SW-1:0] val;
    int          hs;
  } exp_t;

  exp_t          sb[$];
  logic [SW-1:0] mh[NCH][$];
  int            next_prio = 0;
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d, got no event expected one", name, cyc);
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      mh[c].delete();
      repeat (8) mh[c].push_back('0);
    end
    next_prio = 0;
    sb.delete();
  endfunction

  function automatic logic [SW-1:0] mean(input int c);
    longint s = 0;
    foreach (mh[c][i]) s += longint'(mh[c][i]);
    return SW'(s / 8);
  endfunction

  function automatic int expected_grant(input logic [NCH-1:0] v);
    for (int k = 0; k < NCH; k++) begin
      int i2;
      i2 = (next_prio + k) % NCH;
      if (v[i2]) return i2;
    end
    return -1;
  endfunction

  // Input side: predict the grant, and on a handshake push the expected envelope.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      logic [NCH-1:0] exp_rdy;
      int g;
      exp_t e;
      exp_rdy = '0;
      g = -1;
      if (sb.size() == 0) begin
        g = expected_grant(in_valid);
        if (g >= 0) exp_rdy[g] = 1'b1;
      end
      chk("in_ready", in_ready, exp_rdy);
      if (g >= 0) begin
        mh[g].push_back(in_sample[g*SW +: SW]);
        void'(mh[g].pop_front());
        e.ch  = g;
        e.val = mean(g);
        e.hs  = cyc;
        sb.push_back(e);
      end
    end
  end

  // Output side: compare presented results against the scoreboard head.
  always @(negedge clk) begin
    #1;
    if (rst === 1'b1) begin
      if (sb.size() == 0) begin
        chk("out_valid_idle", out_valid, 1'b0);
        chk("busy_idle", busy, 1'b0);
      end else begin
        exp_t e;
        e = sb[0];
        chk("busy", busy, cyc > e.hs);
        chk("out_valid", out_valid, (cyc - e.hs) >= 9);
        if (out_valid) begin
          chk("out_channel", out_channel, e.ch);
          chk("out_sample", out_sample, e.val);
        end
        if (out_valid && out_ready) begin
          $display("txn ch=%0d env=0x%06h exp=0x%06h cycle=%0d", out_channel, out_sample, e.val, cyc);
          void'(sb.pop_front());
          next_prio = (e.ch + 1) % NCH;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    in_valid = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, '0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_channel", out_channel, '0);
    chk("rst_out_sample", out_sample, '0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic send(input int ch, input logic [SW-1:0] v);
    bit hs;
    hs = 1'b0;
    in_sample[ch*SW +: SW] = v;
    in_valid[ch] = 1'b1;
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge clk);
      hs = in_ready[ch];
      @(posedge clk);
      #1;
    end
    in_valid[ch] = 1'b0;
    if (!hs) fail_timeout("send_handshake");
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      #2;
      done = (sb.size() == 0) && !busy;
    end
    if (!done) fail_timeout("wait_done");
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = '0;
    in_sample = '0;
    out_ready = 1'b1;
    do_reset();

    // Ramp on ch0
    for (int i = 0; i < 8; i++) begin
      send(0, 24'h000800);
      wait_done();
    end

    // Full scale on ch2, then a single zero
    for (int i = 0; i < 8; i++) send(2, 24'hFFFFFF);
    send(2, 24'h000000);
    wait_done();

    // Fairness with all channels requesting
    for (int c = 0; c < NCH; c++) in_sample[c*SW +: SW] = SW'(32'h10 * (c + 1));
    in_valid = '1;
    repeat (90) @(posedge clk);
    #1;
    in_valid = '0;
    wait_done();

    // Backpressure with other channels waiting
    out_ready = 1'b0;
    send(1, 24'h123456);
    in_valid = 4'b1101;
    repeat (30) @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = '0;
    wait_done();

    // Isolation between ch1 and ch3
    do_reset();
    for (int i = 0; i < 8; i++) send(1, 24'h000080);
    send(3, 24'h000400);
    send(1, 24'h000080);
    wait_done();

    // Reset in the middle of accumulation
    send(0, 24'h00ABCD);
    repeat (4) @(posedge clk);
    #1;
    do_reset();
    repeat (20) @(posedge clk);
    #1;
    send(0, 24'h000008);
    wait_done();

    // Randomized traffic with random backpressure
    for (int i = 0; i < 3000; i++) begin
      in_valid  = NCH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NCH; c++) begin
        case ($urandom_range(0, 3))
          0:       in_sample[c*SW +: SW] = '0;
          1:       in_sample[c*SW +: SW] = '1;
          default: in_sample[c*SW +: SW] = SW'($urandom);
        endcase
      end
      @(posedge clk);
      #1;
    end
    in_valid  = '0;
    out_ready = 1'b1;
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
